// File: rtl/rc_net_composer_nch.sv
// rc_net_composer_nch
// Folds up to NSRC Thevenin source slots per net into one equivalent source,
// slews each net voltage towards that source with a first-order RC step and
// runs a hysteretic, debounced comparator per net. Each pass is started by
// `start`, works one slot per clock per net, and ends with a `done` pulse.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   start      request one composition/update pass (ignored while busy)
//   src_en     slot enables, bit c*NSRC+s
//   src_r      slot resistances (Ohm, 0 = open), field c*NSRC+s of RW bits
//   src_v      slot voltages (mV), field c*NSRC+s of VW bits
//   busy       pass in progress
//   done       one-cycle pulse when a pass completes
//   v_out      net voltages, VW bits per net
//   r_out      equivalent net resistance, RW bits per net (0 = open)
//   open       net has no effective source
//   comp       debounced comparator per net
//   comp_chg   one-cycle pulse when comp toggles
module rc_net_composer_nch #(
  parameter int NCH       = 2,
  parameter int NSRC      = 9,
  parameter int VW        = 16,
  parameter int RW        = 24,
  parameter int TAU_SHIFT = 4,
  parameter int VTH_HI    = 1200,
  parameter int VTH_LO    = 1000,
  parameter int DEB       = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NCH*NSRC-1:0]    src_en,
  input  logic [NCH*NSRC*RW-1:0] src_r,
  input  logic [NCH*NSRC*VW-1:0] src_v,
  output logic                   busy,
  output logic                   done,
  output logic [NCH*VW-1:0]      v_out,
  output logic [NCH*RW-1:0]      r_out,
  output logic [NCH-1:0]         open,
  output logic [NCH-1:0]         comp,
  output logic [NCH-1:0]         comp_chg
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int DW = (DEB > 1) ? $clog2(DEB + 1) : 1;

  localparam logic [CW-1:0] CH_LAST   = CW'(NCH - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NSRC - 1);
  localparam logic [VW-1:0] VTH_HI_V  = VW'(VTH_HI);
  localparam logic [VW-1:0] VTH_LO_V  = VW'(VTH_LO);
  localparam logic [DW-1:0] DEB_V     = DW'(DEB);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_UPD  = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  logic [1:0]    state_r;
  logic [CW-1:0] ch_r;
  logic [SW-1:0] slot_r;
  logic [VW-1:0] v_acc_r;
  logic [RW-1:0] r_acc_r;
  logic          busy_r;
  logic          done_r;

  // Input snapshot taken when a pass is accepted, so the inputs may change
  // freely while the pass runs.
  logic          snap_en_r [NCH][NSRC];
  logic [RW-1:0] snap_r_r  [NCH][NSRC];
  logic [VW-1:0] snap_v_r  [NCH][NSRC];

  logic [VW-1:0] v_out_r   [NCH];
  logic [RW-1:0] r_out_r   [NCH];
  logic [DW-1:0] deb_cnt_r [NCH];
  logic [NCH-1:0] open_r;
  logic [NCH-1:0] comp_r;
  logic [NCH-1:0] comp_chg_r;

  // ---------------- slot fold (parallel combination) ----------------
  logic          slot_en_s;
  logic [RW-1:0] slot_r_s;
  logic [VW-1:0] slot_v_s;
  logic          slot_eff_s;
  logic [RW:0]       r_sum_s;
  logic [VW+RW-1:0]  prod_a_s;
  logic [VW+RW-1:0]  prod_b_s;
  logic [VW+RW:0]    v_num_s;
  logic [VW+RW:0]    v_div_s;
  logic [2*RW-1:0]   r_prod_s;
  logic [2*RW-1:0]   r_div_s;
  logic [VW-1:0]     acc_v_nx_s;
  logic [RW-1:0]     acc_r_nx_s;

  assign slot_en_s  = snap_en_r[ch_r][slot_r];
  assign slot_r_s   = snap_r_r[ch_r][slot_r];
  assign slot_v_s   = snap_v_r[ch_r][slot_r];
  assign slot_eff_s = slot_en_s && (slot_r_s != {RW{1'b0}});

  // Divisor is only non-zero-guarded by use: the quotients are consumed only
  // when both r_acc and the slot resistance are non-zero.
  assign r_sum_s  = {1'b0, r_acc_r} + {1'b0, slot_r_s};
  assign prod_a_s = {{RW{1'b0}}, slot_v_s} * {{VW{1'b0}}, r_acc_r};
  assign prod_b_s = {{RW{1'b0}}, v_acc_r} * {{VW{1'b0}}, slot_r_s};
  // The numerator keeps one extra bit so the sum of two full products cannot wrap.
  assign v_num_s  = {1'b0, prod_a_s} + {1'b0, prod_b_s};
  assign v_div_s  = v_num_s / {{VW{1'b0}}, r_sum_s};
  assign r_prod_s = {{RW{1'b0}}, r_acc_r} * {{RW{1'b0}}, slot_r_s};
  assign r_div_s  = r_prod_s / {{(RW-1){1'b0}}, r_sum_s};

  // Next accumulator value for the slot under inspection.
  always_comb begin
    acc_v_nx_s = v_acc_r;
    acc_r_nx_s = r_acc_r;
    if (!slot_eff_s) begin
      acc_v_nx_s = v_acc_r;
      acc_r_nx_s = r_acc_r;
    end else if (r_acc_r == {RW{1'b0}}) begin
      acc_v_nx_s = slot_v_s;
      acc_r_nx_s = slot_r_s;
    end else begin
      acc_v_nx_s = v_div_s[VW-1:0];
      acc_r_nx_s = r_div_s[RW-1:0];
    end
  end

  // ---------------- net update: slew + comparator ----------------
  logic [VW-1:0]        v_cur_s;
  logic signed [VW:0]   diff_s;
  logic [VW:0]          mag_s;
  logic signed [VW:0]   step_s;
  logic [VW-1:0]        v_new_s;
  logic                 raw_s;
  logic [DW-1:0]        cnt_inc_s;
  logic [DW-1:0]        cnt_nx_s;
  logic                 flip_s;

  assign v_cur_s   = v_out_r[ch_r];
  assign diff_s    = $signed({1'b0, v_acc_r}) - $signed({1'b0, v_cur_s});
  assign mag_s     = diff_s[VW] ? $unsigned(-diff_s) : $unsigned(diff_s);
  assign step_s    = diff_s >>> TAU_SHIFT;
  assign cnt_inc_s = deb_cnt_r[ch_r] + DW'(1'b1);

  // Slewed voltage: snap to target once within one step, hold on an open net.
  always_comb begin
    v_new_s = v_cur_s;
    if (r_acc_r == {RW{1'b0}}) begin
      v_new_s = v_cur_s;
    end else if ((mag_s >> TAU_SHIFT) == {(VW+1){1'b0}}) begin
      v_new_s = v_acc_r;
    end else begin
      // Modular add is exact here: the result lies between v_cur and v_acc.
      v_new_s = v_cur_s + step_s[VW-1:0];
    end
  end

  // Hysteretic raw comparator on the freshly updated voltage.
  always_comb begin
    raw_s = 1'b0;
    if (comp_r[ch_r]) begin
      raw_s = !(v_new_s < VTH_LO_V);
    end else begin
      raw_s = (v_new_s > VTH_HI_V);
    end
  end

  // Debounce: DEB consecutive disagreeing updates flip comp.
  always_comb begin
    cnt_nx_s = {DW{1'b0}};
    flip_s   = 1'b0;
    if (raw_s == comp_r[ch_r]) begin
      cnt_nx_s = {DW{1'b0}};
    end else if (cnt_inc_s == DEB_V) begin
      cnt_nx_s = {DW{1'b0}};
      flip_s   = 1'b1;
    end else begin
      cnt_nx_s = cnt_inc_s;
    end
  end

  // Sequencer, snapshot, accumulators and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      ch_r       <= {CW{1'b0}};
      slot_r     <= {SW{1'b0}};
      v_acc_r    <= {VW{1'b0}};
      r_acc_r    <= {RW{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      open_r     <= {NCH{1'b0}};
      comp_r     <= {NCH{1'b0}};
      comp_chg_r <= {NCH{1'b0}};
      for (int c = 0; c < NCH; c++) begin
        v_out_r[c]   <= {VW{1'b0}};
        r_out_r[c]   <= {RW{1'b0}};
        deb_cnt_r[c] <= {DW{1'b0}};
        for (int s = 0; s < NSRC; s++) begin
          snap_en_r[c][s] <= 1'b0;
          snap_r_r[c][s]  <= {RW{1'b0}};
          snap_v_r[c][s]  <= {VW{1'b0}};
        end
      end
    end else begin
      done_r     <= 1'b0;
      comp_chg_r <= {NCH{1'b0}};
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            for (int c = 0; c < NCH; c++) begin
              for (int s = 0; s < NSRC; s++) begin
                snap_en_r[c][s] <= src_en[c*NSRC + s];
                snap_r_r[c][s]  <= src_r[(c*NSRC + s)*RW +: RW];
                snap_v_r[c][s]  <= src_v[(c*NSRC + s)*VW +: VW];
              end
            end
            ch_r    <= {CW{1'b0}};
            slot_r  <= {SW{1'b0}};
            v_acc_r <= {VW{1'b0}};
            r_acc_r <= {RW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= ST_ACC;
          end
        end
        ST_ACC: begin
          v_acc_r <= acc_v_nx_s;
          r_acc_r <= acc_r_nx_s;
          if (slot_r == SLOT_LAST) begin
            state_r <= ST_UPD;
          end else begin
            slot_r <= slot_r + SW'(1'b1);
          end
        end
        ST_UPD: begin
          open_r[ch_r]    <= (r_acc_r == {RW{1'b0}});
          r_out_r[ch_r]   <= r_acc_r;
          v_out_r[ch_r]   <= v_new_s;
          deb_cnt_r[ch_r] <= cnt_nx_s;
          if (flip_s) begin
            comp_r[ch_r]     <= ~comp_r[ch_r];
            comp_chg_r[ch_r] <= 1'b1;
          end
          slot_r  <= {SW{1'b0}};
          v_acc_r <= {VW{1'b0}};
          r_acc_r <= {RW{1'b0}};
          if (ch_r == CH_LAST) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_FIN;
          end else begin
            ch_r    <= ch_r + CW'(1'b1);
            state_r <= ST_ACC;
          end
        end
        ST_FIN: begin
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign open     = open_r;
  assign comp     = comp_r;
  assign comp_chg = comp_chg_r;

  for (genvar g = 0; g < NCH; g++) begin : g_flat
    assign v_out[g*VW +: VW] = v_out_r[g];
    assign r_out[g*RW +: RW] = r_out_r[g];
  end

  // Quotient high bits are provably zero; gathered here to document that.
  logic unused_s;
  assign unused_s = &{1'b0, v_div_s[VW+RW:VW], r_div_s[2*RW-1:RW], step_s[VW]};

endmodule

// File: tb/tb_rc_net_composer_nch.sv
// Bench for rc_net_composer_nch: two instances (TAU_SHIFT 0 and 2) share
// stimulus; a behavioural model folds the slot snapshot with plain integer
// arithmetic and predicts voltages, resistances, comparator and pulses.
module tb_rc_net_composer_nch;
  localparam int NCH = 2, NSRC = 9, VW = 16, RW = 24;
  localparam int VTH_HI = 1200, VTH_LO = 1000, DEB = 2;

  logic clk = 1'b0;
  logic rst, start;
  logic [NCH*NSRC-1:0]    src_en;
  logic [NCH*NSRC*RW-1:0] src_r;
  logic [NCH*NSRC*VW-1:0] src_v;
  logic busy_a, done_a, busy_b, done_b;
  logic [NCH*VW-1:0] v_out_a, v_out_b;
  logic [NCH*RW-1:0] r_out_a, r_out_b;
  logic [NCH-1:0] open_a, comp_a, chg_a, open_b, comp_b, chg_b;

  rc_net_composer_nch #(.TAU_SHIFT(0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .src_en(src_en), .src_r(src_r), .src_v(src_v),
    .busy(busy_a), .done(done_a), .v_out(v_out_a), .r_out(r_out_a),
    .open(open_a), .comp(comp_a), .comp_chg(chg_a));

  rc_net_composer_nch #(.TAU_SHIFT(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .src_en(src_en), .src_r(src_r), .src_v(src_v),
    .busy(busy_b), .done(done_b), .v_out(v_out_b), .r_out(r_out_b),
    .open(open_b), .comp(comp_b), .comp_chg(chg_b));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [NCH*NSRC-1:0]    sn_en;
  logic [NCH*NSRC*RW-1:0] sn_r;
  logic [NCH*NSRC*VW-1:0] sn_v;
  longint m_v [2][NCH];
  longint m_r [2][NCH];
  bit     m_open [2][NCH];
  bit     m_comp [2][NCH];
  bit     m_chg  [2][NCH];
  int     m_cnt  [2][NCH];
  int     tau_of [2] = '{0, 2};
  bit     seen_chg [2][NCH];
  int     n_done [2];
  int     done_cyc [2];
  int     n_busy [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] get_v(input int k, input int c);
    return (k == 0) ? 64'(v_out_a[c*VW +: VW]) : 64'(v_out_b[c*VW +: VW]);
  endfunction
  function automatic logic [63:0] get_r(input int k, input int c);
    return (k == 0) ? 64'(r_out_a[c*RW +: RW]) : 64'(r_out_b[c*RW +: RW]);
  endfunction
  function automatic logic [63:0] get_open(input int k, input int c);
    return (k == 0) ? 64'(open_a[c]) : 64'(open_b[c]);
  endfunction
  function automatic logic [63:0] get_comp(input int k, input int c);
    return (k == 0) ? 64'(comp_a[c]) : 64'(comp_b[c]);
  endfunction

  function automatic longint floor_div(input longint d, input longint q);
    if (d >= 0) return d / q;
    return -((-d + q - 1) / q);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < NCH; c++) begin
        m_v[k][c] = 0; m_r[k][c] = 0; m_open[k][c] = 0;
        m_comp[k][c] = 0; m_chg[k][c] = 0; m_cnt[k][c] = 0;
      end
  endtask

  // One pass of the reference: order-dependent parallel fold, slew, comparator.
  task automatic model_pass(input int k);
    for (int c = 0; c < NCH; c++) begin
      longint va, ra, v, r, d, q, sum;
      bit raw;
      va = 0; ra = 0;
      for (int s = 0; s < NSRC; s++) begin
        int idx;
        idx = c*NSRC + s;
        v = sn_v[idx*VW +: VW];
        r = sn_r[idx*RW +: RW];
        if (sn_en[idx] && r != 0) begin
          if (ra == 0) begin va = v; ra = r; end
          else begin sum = ra + r; va = (v*ra + va*r) / sum; ra = (ra*r) / sum; end
        end
      end
      m_chg[k][c] = 0;
      if (ra == 0) begin
        m_open[k][c] = 1; m_r[k][c] = 0;
      end else begin
        m_open[k][c] = 0; m_r[k][c] = ra;
        d = va - m_v[k][c];
        q = 2 ** tau_of[k];
        if (((d < 0) ? -d : d) < q) m_v[k][c] = va;
        else m_v[k][c] = m_v[k][c] + floor_div(d, q);
      end
      raw = m_comp[k][c] ? (m_v[k][c] >= VTH_LO) : (m_v[k][c] > VTH_HI);
      if (raw == m_comp[k][c]) m_cnt[k][c] = 0;
      else begin
        m_cnt[k][c]++;
        if (m_cnt[k][c] >= DEB) begin
          m_comp[k][c] = !m_comp[k][c]; m_chg[k][c] = 1; m_cnt[k][c] = 0;
        end
      end
    end
  endtask

  task automatic clear_slots();
    src_en = '0; src_r = '0; src_v = '0;
  endtask

  task automatic set_slot(input int c, input int s, input bit en, input int r, input int v);
    src_en[c*NSRC + s] = en;
    src_r[(c*NSRC + s)*RW +: RW] = RW'(r);
    src_v[(c*NSRC + s)*VW +: VW] = VW'(v);
  endtask

  task automatic random_inputs();
    for (int i = 0; i < NCH*NSRC; i++) begin
      int sel;
      sel = $urandom_range(0, 5);
      src_en[i] = 1'($urandom_range(0, 1));
      src_r[i*RW +: RW] = (sel == 0) ? RW'(0) : (sel == 1) ? RW'($urandom) : RW'($urandom_range(1, 50000));
      src_v[i*VW +: VW] = (sel == 2) ? VW'($urandom) : VW'($urandom_range(0, 5000));
    end
  endtask

  task automatic check_state(input string tag);
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < NCH; c++) begin
        check($sformatf("%s v_out k%0d c%0d", tag, k, c), get_v(k, c), 64'(m_v[k][c]));
        check($sformatf("%s r_out k%0d c%0d", tag, k, c), get_r(k, c), 64'(m_r[k][c]));
        check($sformatf("%s open k%0d c%0d", tag, k, c), get_open(k, c), 64'(m_open[k][c]));
        check($sformatf("%s comp k%0d c%0d", tag, k, c), get_comp(k, c), 64'(m_comp[k][c]));
      end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " busy_a"}, 64'(busy_a), 64'd0);
    check({tag, " done_a"}, 64'(done_a), 64'd0);
    check({tag, " v_out_a"}, 64'(v_out_a), 64'd0);
    check({tag, " r_out_a"}, 64'(r_out_a), 64'd0);
    check({tag, " open_a"}, 64'(open_a), 64'd0);
    check({tag, " comp_a"}, 64'(comp_a), 64'd0);
    check({tag, " chg_a"}, 64'(chg_a), 64'd0);
    check({tag, " busy_b"}, 64'(busy_b), 64'd0);
    check({tag, " v_out_b"}, 64'(v_out_b), 64'd0);
    check({tag, " open_b/comp_b"}, 64'({open_b, comp_b, chg_b, done_b}), 64'd0);
  endtask

  // Run one pass; poke re-asserts start mid-pass and in the FIN cycle and
  // scrambles the inputs while busy.
  task automatic run_pass(input bit poke, input string tag);
    sn_en = src_en; sn_r = src_r; sn_v = src_v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_done[k] = 0; done_cyc[k] = 0; n_busy[k] = 0;
      for (int c = 0; c < NCH; c++) seen_chg[k][c] = 0;
    end
    if (poke) random_inputs();
    for (int i = 1; i <= 24; i++) begin
      if (done_a) begin n_done[0]++; done_cyc[0] = i; end
      if (done_b) begin n_done[1]++; done_cyc[1] = i; end
      if (busy_a) n_busy[0]++;
      if (busy_b) n_busy[1]++;
      for (int c = 0; c < NCH; c++) begin
        seen_chg[0][c] |= chg_a[c];
        seen_chg[1][c] |= chg_b[c];
      end
      start = poke && (i == 3 || i == 21);
      @(posedge clk); #1;
    end
    start = 1'b0;
    model_pass(0);
    model_pass(1);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s done count k%0d", tag, k), 64'(n_done[k]), 64'd1);
      check($sformatf("%s done cycle k%0d", tag, k), 64'(done_cyc[k]), 64'(NCH*(NSRC+1)+1));
      check($sformatf("%s busy cycles k%0d", tag, k), 64'(n_busy[k]), 64'(NCH*(NSRC+1)));
      for (int c = 0; c < NCH; c++)
        check($sformatf("%s comp_chg k%0d c%0d", tag, k, c), 64'(seen_chg[k][c]), 64'(m_chg[k][c]));
    end
    check_state(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int nd;
    int exp_b [4] = '{825, 1443, 1907, 2255};
    rst = 1'b1; start = 1'b0;
    clear_slots();
    do_reset();
    check_reset("reset");

    // Single source on ch0; dut_b slews towards it.
    set_slot(0, 0, 1'b1, 1500, 3300);
    for (int p = 0; p < 4; p++) begin
      run_pass(1'b0, $sformatf("single p%0d", p + 1));
      if (p == 0) begin
        check("t1 v_out0", get_v(0, 0), 64'd3300);
        check("t1 r_out0", get_r(0, 0), 64'd1500);
        check("t1 open0", get_open(0, 0), 64'd0);
        check("t1 open1", get_open(0, 1), 64'd1);
        check("t1 v_out1", get_v(0, 1), 64'd0);
      end
      check($sformatf("t3 slew p%0d", p + 1), get_v(1, 0), 64'(exp_b[p]));
      if (p == 2) check("t3 comp_chg0 p3", 64'(seen_chg[1][0]), 64'd1);
    end

    // Two effective slots plus an enabled R=0 slot that must be ignored.
    do_reset();
    clear_slots();
    set_slot(0, 0, 1'b1, 1500, 3300);
    set_slot(0, 1, 1'b1, 15000, 0);
    set_slot(0, 2, 1'b1, 0, 5000);
    run_pass(1'b0, "pair p1");
    check("t2 v_out0", get_v(0, 0), 64'd3000);
    check("t2 r_out0", get_r(0, 0), 64'd1363);
    check("t2 comp0 p1", get_comp(0, 0), 64'd0);
    run_pass(1'b0, "pair p2");
    check("t2 comp0 p2", get_comp(0, 0), 64'd1);
    check("t2 comp_chg0 p2", 64'(seen_chg[0][0]), 64'd1);

    // Hysteresis band: 1100 mV holds comp high, 900 mV drops it after DEB passes.
    clear_slots();
    set_slot(0, 0, 1'b1, 1500, 1100);
    for (int p = 0; p < 5; p++) begin
      run_pass(1'b0, $sformatf("hyst1100 p%0d", p + 1));
      check($sformatf("t4 comp0 1100 p%0d", p + 1), get_comp(0, 0), 64'd1);
    end
    set_slot(0, 0, 1'b1, 1500, 900);
    run_pass(1'b0, "hyst900 p1");
    check("t4 comp0 900 p1", get_comp(0, 0), 64'd1);
    run_pass(1'b0, "hyst900 p2");
    check("t4 comp0 900 p2", get_comp(0, 0), 64'd0);

    // Single-pass glitches never reach DEB and clear the counter.
    do_reset();
    clear_slots();
    for (int p = 0; p < 5; p++) begin
      set_slot(0, 0, 1'b1, 1000, (p % 2 == 1) ? 3300 : 0);
      run_pass(1'b0, $sformatf("glitch p%0d", p + 1));
      check($sformatf("t5 comp0 p%0d", p + 1), get_comp(0, 0), 64'd0);
    end
    set_slot(0, 0, 1'b1, 1000, 3300);
    run_pass(1'b0, "glitch p6");
    check("t5 comp0 p6", get_comp(0, 0), 64'd0);

    // Randomised passes with start pokes and input churn while busy.
    for (int p = 0; p < 24; p++) begin
      random_inputs();
      run_pass(1'b1, $sformatf("rand p%0d", p + 1));
    end

    // Reset in the middle of a pass aborts it with no done pulse.
    random_inputs();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_reset("midreset");
    nd = 0;
    for (int i = 0; i < 25; i++) begin
      if (done_a || done_b) nd++;
      @(posedge clk); #1;
    end
    check("midreset no done", 64'(nd), 64'd0);
    random_inputs();
    run_pass(1'b0, "after reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
